// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
// The state encoding, owner codes and the default byte-enable pattern live here.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Wide enough for any practical data width; users slice the low bits.
  localparam logic [63:0] BE_ALL = {64{1'b1}};

endpackage

// File: rtl/mem_bus_arbiter_arb.sv
// Priority choice between fetch and data requests, with a saturating starve counter.
// The counter lets the fetch port win once the data port has won STARVE_MAX times in a row.
module arb_prio_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_req,
  input  logic data_req,
  input  logic grant_en,
  output logic grant_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_r;
  logic          inst_due_s;

  // Priority choice: data wins unless a waiting fetch has been starved long enough
  always_comb begin
    inst_due_s = inst_req && (starve_cnt_r == CNT_MAX);
    grant_data = data_req && !inst_due_s;
  end

  // Starve counter: counts data grants taken while fetch waits, clears otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_r <= '0;
    end else if (grant_en) begin
      if (grant_data && inst_req) begin
        if (starve_cnt_r != CNT_MAX) begin
          starve_cnt_r <= starve_cnt_r + CW'(1);
        end
      end else begin
        starve_cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-outstanding memory bus between the fetch and data ports.
// Holds the FSM, latched bus registers, per-port read data and the transaction timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ready,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [DATA_W/8-1:0] data_be,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ready,
  output logic                data_stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_timeout
);

  localparam int BE_W = DATA_W / 8;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              owner_r;
  logic              bus_we_r;
  logic [BE_W-1:0]   bus_be_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic [DATA_W-1:0] inst_rdata_r;
  logic [DATA_W-1:0] data_rdata_r;
  logic [TW-1:0]     tmo_cnt_r;
  logic              timeout_r;

  logic grant_en_s;
  logic grant_data_s;
  logic tmo_hit_s;
  logic capture_s;
  logic abort_s;

  arb_prio_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .data_req  (data_req),
    .grant_en  (grant_en_s),
    .grant_data(grant_data_s)
  );

  // Transaction events; a response arriving on the timeout cycle still wins over the abort
  always_comb begin
    grant_en_s = (state_r == IDLE) && (inst_req || data_req);
    tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
    capture_s  = ((state_r == REQ) && bus_gnt && bus_rvalid) ||
                 ((state_r == WAIT) && bus_rvalid);
    abort_s    = !capture_s && tmo_hit_s && ((state_r == REQ) || (state_r == WAIT));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = grant_en_s ? REQ : IDLE;
      REQ: begin
        if (capture_s || abort_s) begin
          state_nxt_s = RESP;
        end else if (bus_gnt) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT:    state_nxt_s = (capture_s || abort_s) ? RESP : WAIT;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from registered state and bus registers
  always_comb begin
    bus_req     = (state_r == REQ);
    inst_ready  = (state_r == RESP) && (owner_r == OWN_INST);
    data_ready  = (state_r == RESP) && (owner_r == OWN_DATA);
    inst_stall  = inst_req && !inst_ready;
    data_stall  = data_req && !data_ready;
    bus_we      = bus_we_r;
    bus_be      = bus_be_r;
    bus_addr    = bus_addr_r;
    bus_wdata   = bus_wdata_r;
    inst_rdata  = inst_rdata_r;
    data_rdata  = data_rdata_r;
    bus_timeout = timeout_r;
  end

  // Bus registers, owner, read-data capture and timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_r      <= OWN_INST;
      bus_we_r     <= 1'b0;
      bus_be_r     <= '0;
      bus_addr_r   <= '0;
      bus_wdata_r  <= '0;
      inst_rdata_r <= '0;
      data_rdata_r <= '0;
      tmo_cnt_r    <= '0;
      timeout_r    <= 1'b0;
    end else begin
      timeout_r <= abort_s;
      if (grant_en_s) begin
        if (grant_data_s) begin
          owner_r     <= OWN_DATA;
          bus_we_r    <= data_we;
          bus_be_r    <= data_be;
          bus_addr_r  <= data_addr;
          bus_wdata_r <= data_wdata;
        end else begin
          owner_r     <= OWN_INST;
          bus_we_r    <= 1'b0;
          bus_be_r    <= BE_ALL[BE_W-1:0];
          bus_addr_r  <= inst_addr;
          bus_wdata_r <= '0;
        end
      end
      if ((state_r == REQ) || (state_r == WAIT)) begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end else begin
        tmo_cnt_r <= '0;
      end
      // Stores never overwrite the load data; an abort hands the owner zero
      if (capture_s) begin
        if (owner_r == OWN_INST) begin
          inst_rdata_r <= bus_rdata;
        end else if (!bus_we_r) begin
          data_rdata_r <= bus_rdata;
        end
      end else if (abort_s) begin
        if (owner_r == OWN_INST) begin
          inst_rdata_r <= '0;
        end else begin
          data_rdata_r <= '0;
        end
      end
    end
  end

endmodule
